pulse_stretcher: RTL and testbench

- Turns single-cycle strobes (for example the output of an edge detector) into a clean, fixed-width active-high level pulse.
- The output's falling edge is deterministic and is flagged by a one-cycle done strobe.
- A programmable hold-off gap after each pulse guarantees a minimum low time before the next pulse.
- Sits between event sources (button edges, game-timer ticks) and downstream consumers that need a level of known duration (LED/buzzer drive, sprite flash, re-arm of edge detectors).

---
 rtl/pulse_stretcher.sv | 126 ++++++++++++
 tb/tb_pulse_stretcher.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_stretcher
//  Description : Stretches single-cycle strobes into fixed-width level pulses
//                with a done strobe and a programmable hold-off gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_stretcher #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 3,
  parameter int RETRIGGER = 0,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger_in,
  output logic pulse_out,
  output logic busy,
  output logic done,
  output logic trig_dropped
);

  localparam logic [CNT_W-1:0] c_pulse_reload = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] c_gap_reload   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam bit               c_retrig       = (RETRIGGER != 0);
  localparam bit               c_has_gap      = (GAP_LEN > 0);

  // Elaboration-time sanity checks on the parameter set.
  generate
    if (PULSE_LEN < 1) begin : g_bad_pulse_len
      $error("pulse_stretcher: PULSE_LEN must be >= 1");
    end
    if (GAP_LEN < 0) begin : g_bad_gap_len
      $error("pulse_stretcher: GAP_LEN must be >= 0");
    end
    if ((CNT_W < 31) && ((PULSE_LEN >= (1 << CNT_W)) || (GAP_LEN >= (1 << CNT_W)))) begin : g_bad_cnt_w
      $error("pulse_stretcher: CNT_W too narrow for PULSE_LEN/GAP_LEN");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_busy;
  logic             r_done;
  logic             r_dropped;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_dropped <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (trigger_in) begin
            r_state <= ST_ACTIVE;
            r_cnt   <= c_pulse_reload;
            r_pulse <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        ST_ACTIVE: begin
          // A retrigger on the final count extends the pulse seamlessly.
          if (trigger_in && c_retrig) begin
            r_cnt <= c_pulse_reload;
          end else begin
            r_dropped <= trigger_in;
            if (w_cnt_zero) begin
              r_pulse <= 1'b0;
              r_done  <= 1'b1;
              if (c_has_gap) begin
                r_state <= ST_GAP;
                r_cnt   <= c_gap_reload;
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end

        ST_GAP: begin
          r_dropped <= trigger_in;
          if (w_cnt_zero) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_pulse <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_out    = r_pulse;
  assign busy         = r_busy;
  assign done         = r_done;
  assign trig_dropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_stretcher
//  Description : Directed vector bench for pulse_stretcher in three configs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_stretcher;

  localparam int NCYC = 40;
  localparam int NVEC = 8;

  logic       clk;
  logic       rst_v  [3];
  logic       trig_v [3];
  logic [3:0] obs    [3];
  logic       p0, b0, d0, x0, p1, b1, d1, x1, p2, b2, d2, x2;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: defaults, 1: RETRIGGER=1, 2: GAP_LEN=0
  pulse_stretcher #(.PULSE_LEN(4), .GAP_LEN(3), .RETRIGGER(0), .CNT_W(8)) u_dut0 (
    .clk(clk), .reset(rst_v[0]), .trigger_in(trig_v[0]),
    .pulse_out(p0), .busy(b0), .done(d0), .trig_dropped(x0));
  pulse_stretcher #(.PULSE_LEN(4), .GAP_LEN(3), .RETRIGGER(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset(rst_v[1]), .trigger_in(trig_v[1]),
    .pulse_out(p1), .busy(b1), .done(d1), .trig_dropped(x1));
  pulse_stretcher #(.PULSE_LEN(4), .GAP_LEN(0), .RETRIGGER(0), .CNT_W(8)) u_dut2 (
    .clk(clk), .reset(rst_v[2]), .trigger_in(trig_v[2]),
    .pulse_out(p2), .busy(b2), .done(d2), .trig_dropped(x2));

  assign obs[0] = {p0, b0, d0, x0};
  assign obs[1] = {p1, b1, d1, x1};
  assign obs[2] = {p2, b2, d2, x2};

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] trig;
    logic [63:0] rst;
    logic [63:0] pulse;
    logic [63:0] busy;
    logic [63:0] done;
    logic [63:0] drop;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bt(input int n);
    return rng(n, n);
  endfunction

  task automatic check(input string name, input int cyc, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got pulse/busy/done/drop=%b, expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic t);
    for (int d = 0; d < 3; d++) begin
      rst_v[d]  = (d == sel) ? r : 1'b1;
      trig_v[d] = (d == sel) ? t : 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] exp;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      if (c >= 2) begin
        exp = {v.pulse[c], v.busy[c], v.done[c], v.drop[c]};
        check(v.name, c, obs[v.sel], exp);
      end
      drive(v.sel, v.rst[c] | (c < 2), v.trig[c]);
    end
  endtask

  initial begin
    logic [63:0] m_p, m_d, m_x, m_t;
    int          high_cnt;
    bit          seen;

    for (int d = 0; d < 3; d++) begin
      rst_v[d]  = 1'b1;
      trig_v[d] = 1'b0;
    end

    vecs[0] = '{"single", 0, bt(10), 64'd0, rng(11,14), rng(11,17), bt(15), 64'd0};
    vecs[1] = '{"drop_active", 0, bt(10) | bt(12), 64'd0, rng(11,14), rng(11,17), bt(15), bt(13)};
    vecs[2] = '{"retrig_mid", 1, bt(10) | bt(13), 64'd0, rng(11,17), rng(11,20), bt(18), 64'd0};
    vecs[3] = '{"retrig_last", 1, bt(10) | bt(14), 64'd0, rng(11,18), rng(11,21), bt(19), 64'd0};
    vecs[4] = '{"gap_edge", 0, bt(10) | bt(17) | bt(18), 64'd0,
                rng(11,14) | rng(19,22), rng(11,17) | rng(19,25), bt(15) | bt(23), bt(18)};
    vecs[5] = '{"reset_active", 0, bt(10) | bt(15), bt(12),
                rng(11,12) | rng(16,19), rng(11,12) | rng(16,22), bt(20), 64'd0};
    vecs[6] = '{"reset_gap", 0, bt(10), bt(16), rng(11,14), rng(11,16), bt(15), 64'd0};

    // GAP_LEN=0 with trigger held: 4 high / 1 low repeating.
    m_p = '0; m_d = '0; m_x = '0;
    for (int k = 0; k < 6; k++) begin
      m_p |= rng(11 + 5*k, 14 + 5*k);
      if (15 + 5*k < NCYC) m_d |= bt(15 + 5*k);
      m_x |= rng(12 + 5*k, (15 + 5*k < NCYC) ? 15 + 5*k : NCYC - 1);
    end
    m_t = rng(10, NCYC - 1);
    vecs[7] = '{"gap0_held", 2, m_t, 64'd0, m_p, m_p, m_d, m_x};

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Continuous retrigger holds the pulse; it ends PULSE_LEN cycles after release.
    drive(1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 drive(1, 1'b0, 1'b1);
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      check("retrig_hold", c, {p1, d1, x1}, 3'b100);
      @(posedge clk); #1;
    end
    drive(1, 1'b0, 1'b0);
    high_cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      check("retrig_hold_tail_drop", c, {1'b0, x1}, 2'b00);
      if (d1) seen = 1'b1;
      else if (p1) high_cnt++;
      @(posedge clk); #1;
    end
    check("retrig_release_done_seen", 0, {3'b000, seen}, 4'b0001);
    check("retrig_release_width", 0, 4'(high_cnt), 4'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
